// File: rtl/mask_run_decode.sv
// mask_run_decode: splits each accepted byte-enable mask into maximal runs of
// contiguous set bits and emits one (strtbyte, endbyte) beat per run, lowest
// run first, over a valid/ready handshake.
//
// Optional feature macro: MASK_RUN_DECODE_ZERO_BEAT_EN
//   defined   : an all-zero mask produces one beat with run_zero=1, run_last=1.
//   undefined : an all-zero mask is accepted and silently dropped; run_zero=0.
module mask_run_decode #(
  parameter int unsigned MW = 8,
  parameter int unsigned BW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [MW-1:0] mask,
  input  logic          mask_vld,
  output logic          mask_rdy,
  output logic [BW-1:0] strtbyte,
  output logic [BW-1:0] endbyte,
  output logic          run_last,
  output logic          run_zero,
  output logic          run_vld,
  input  logic          run_rdy
);

  localparam int unsigned MASK_W = MW;
  localparam int unsigned IDX_W  = BW;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  state_e              state_q;
  state_e              state_d;
  logic [MASK_W-1:0]   residual_q;
  logic [MASK_W-1:0]   residual_d;
  logic                zero_q;
  logic                zero_d;

  // Run-finder results for the current residual
  logic [IDX_W-1:0]    run_strt_c;
  logic [IDX_W-1:0]    run_end_c;
  logic [MASK_W-1:0]   run_mask_c;
  logic                run_last_c;
  logic                scan_found;
  logic                scan_done;

  // Handshake helpers
  logic                accept_c;
  logic                load_ok_c;
  logic                run_take_c;

  // State and residual registers; async reset drops any partial mask
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      residual_q <= '0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      residual_q <= residual_d;
      zero_q     <= zero_d;
    end
  end

  // Locate the lowest run: first set bit up to the bit before the next clear bit
  always_comb begin
    run_strt_c = '0;
    run_end_c  = '0;
    run_mask_c = '0;
    scan_found = 1'b0;
    scan_done  = 1'b0;
    for (int i = 0; i < int'(MASK_W); i++) begin
      if (!scan_done) begin
        if (residual_q[i]) begin
          if (!scan_found) begin
            run_strt_c = IDX_W'(i);
          end
          scan_found    = 1'b1;
          run_end_c     = IDX_W'(i);
          run_mask_c[i] = 1'b1;
        end else if (scan_found) begin
          scan_done = 1'b1;
        end
      end
    end
    run_last_c = ((residual_q & ~run_mask_c) == '0);
  end

  // Whether an accepted mask starts a scan or is dropped on the floor
  always_comb begin
`ifdef MASK_RUN_DECODE_ZERO_BEAT_EN
    load_ok_c = 1'b1;
`else
    load_ok_c = (mask != '0);
`endif
    accept_c   = mask_vld && mask_rdy;
    run_take_c = run_vld && run_rdy;
  end

  // Next-state and residual update
  always_comb begin
    state_d    = state_q;
    residual_d = residual_q;
    zero_d     = zero_q;
    unique case (state_q)
      IDLE: begin
        if (accept_c && load_ok_c) begin
          state_d    = SCAN;
          residual_d = mask;
          zero_d     = (mask == '0);
        end
      end
      SCAN: begin
        if (run_take_c) begin
          if (run_last_c) begin
            if (accept_c && load_ok_c) begin
              state_d    = SCAN;
              residual_d = mask;
              zero_d     = (mask == '0);
            end else begin
              state_d    = IDLE;
              residual_d = '0;
              zero_d     = 1'b0;
            end
          end else begin
            residual_d = residual_q & ~run_mask_c;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        residual_d = '0;
        zero_d     = 1'b0;
      end
    endcase
  end

  // Outputs: run fields are zero whenever no run is presented
  always_comb begin
    run_vld  = 1'b0;
    strtbyte = '0;
    endbyte  = '0;
    run_last = 1'b0;
    run_zero = 1'b0;
    mask_rdy = 1'b0;
    unique case (state_q)
      IDLE: begin
        mask_rdy = 1'b1;
      end
      SCAN: begin
        run_vld  = 1'b1;
        strtbyte = run_strt_c;
        endbyte  = run_end_c;
        run_last = run_last_c;
`ifdef MASK_RUN_DECODE_ZERO_BEAT_EN
        run_zero = zero_q;
`else
        run_zero = 1'b0;
`endif
        mask_rdy = run_rdy && run_last_c;
      end
      default: begin
        mask_rdy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mask_run_decode.sv
// Directed bench for mask_run_decode (MW=8): a table of masks with their
// expected run beats, plus hand-written stall, back-to-back, zero-mask and
// mid-scan reset sequences.
module tb_mask_run_decode;

  logic       clk;
  logic       reset;
  logic [7:0] mask;
  logic       mask_vld;
  logic       mask_rdy;
  logic [2:0] strtbyte;
  logic [2:0] endbyte;
  logic       run_last;
  logic       run_zero;
  logic       run_vld;
  logic       run_rdy;

  int n_chk;
  int n_fail;

  typedef struct {
    logic [7:0]  m;
    int          nb;
    logic [11:0] s_pk;
    logic [11:0] e_pk;
  } vec_t;

  vec_t vecs[8];

  mask_run_decode #(.MW(8), .BW(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .mask     (mask),
    .mask_vld (mask_vld),
    .mask_rdy (mask_rdy),
    .strtbyte (strtbyte),
    .endbyte  (endbyte),
    .run_last (run_last),
    .run_zero (run_zero),
    .run_vld  (run_vld),
    .run_rdy  (run_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [2:0] s, input logic [2:0] e,
                          input logic last, input logic zero);
    chk({tag, " run_vld"},  32'(run_vld),  32'd1);
    chk({tag, " strtbyte"}, 32'(strtbyte), 32'(s));
    chk({tag, " endbyte"},  32'(endbyte),  32'(e));
    chk({tag, " run_last"}, 32'(run_last), 32'(last));
    chk({tag, " run_zero"}, 32'(run_zero), 32'(zero));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " run_vld"},  32'(run_vld),  32'd0);
    chk({tag, " strtbyte"}, 32'(strtbyte), 32'd0);
    chk({tag, " endbyte"},  32'(endbyte),  32'd0);
    chk({tag, " run_last"}, 32'(run_last), 32'd0);
    chk({tag, " run_zero"}, 32'(run_zero), 32'd0);
    chk({tag, " mask_rdy"}, 32'(mask_rdy), 32'd1);
  endtask

  // Present one mask in IDLE; returns #1 after the accepting edge
  task automatic send_mask(input logic [7:0] m);
    @(negedge clk);
    mask     = m;
    mask_vld = 1'b1;
    chk("send mask_rdy", 32'(mask_rdy), 32'd1);
    @(posedge clk);
    #1;
    mask_vld = 1'b0;
    mask     = 8'h00;
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    reset    = 1'b1;
    mask     = 8'h00;
    mask_vld = 1'b0;
    run_rdy  = 1'b1;

    // mask, beat count, start indices and end indices packed 3 bits per beat
    vecs[0] = '{8'h3C, 1, {3'd0, 3'd0, 3'd0, 3'd2}, {3'd0, 3'd0, 3'd0, 3'd5}};
    vecs[1] = '{8'h81, 2, {3'd0, 3'd0, 3'd7, 3'd0}, {3'd0, 3'd0, 3'd7, 3'd0}};
    vecs[2] = '{8'h55, 4, {3'd6, 3'd4, 3'd2, 3'd0}, {3'd6, 3'd4, 3'd2, 3'd0}};
    vecs[3] = '{8'hFF, 1, {3'd0, 3'd0, 3'd0, 3'd0}, {3'd0, 3'd0, 3'd0, 3'd7}};
    vecs[4] = '{8'h0F, 1, {3'd0, 3'd0, 3'd0, 3'd0}, {3'd0, 3'd0, 3'd0, 3'd3}};
    vecs[5] = '{8'hF0, 1, {3'd0, 3'd0, 3'd0, 3'd4}, {3'd0, 3'd0, 3'd0, 3'd7}};
    vecs[6] = '{8'h6E, 2, {3'd0, 3'd0, 3'd5, 3'd1}, {3'd0, 3'd0, 3'd6, 3'd3}};
    vecs[7] = '{8'h80, 1, {3'd0, 3'd0, 3'd0, 3'd7}, {3'd0, 3'd0, 3'd0, 3'd7}};

    // Reset state
    #12;
    chk_idle("reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_idle("post-reset");

    // Table: every beat visible one cycle after the previous, run_rdy high
    for (int v = 0; v < 8; v++) begin
      logic [11:0] sp;
      logic [11:0] ep;
      sp = vecs[v].s_pk;
      ep = vecs[v].e_pk;
      send_mask(vecs[v].m);
      for (int k = 0; k < vecs[v].nb; k++) begin
        logic lst;
        lst = (k == vecs[v].nb - 1);
        chk_beat($sformatf("vec%0d beat%0d", v, k), sp[3*k +: 3], ep[3*k +: 3], lst, 1'b0);
        chk($sformatf("vec%0d beat%0d mask_rdy", v, k), 32'(mask_rdy), 32'(lst));
        @(posedge clk);
        #1;
      end
      chk_idle($sformatf("vec%0d done", v));
    end

    // Stall on beat 2 of 0x55; a mask offered meanwhile must be ignored
    send_mask(8'h55);
    chk_beat("stall b0", 3'd0, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    run_rdy  = 1'b0;
    mask     = 8'hFF;
    mask_vld = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk_beat($sformatf("stall hold%0d", c), 3'd2, 3'd2, 1'b0, 1'b0);
      chk("stall mask_rdy", 32'(mask_rdy), 32'd0);
      @(posedge clk);
      #1;
    end
    mask_vld = 1'b0;
    mask     = 8'h00;
    run_rdy  = 1'b1;
    chk_beat("stall b1", 3'd2, 3'd2, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_beat("stall b2", 3'd4, 3'd4, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_beat("stall b3", 3'd6, 3'd6, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk_idle("stall done");

    // Back-to-back 0xFF then 0x0F with no bubble
    @(negedge clk);
    mask     = 8'hFF;
    mask_vld = 1'b1;
    @(posedge clk);
    #1;
    mask = 8'h0F;
    chk_beat("b2b FF", 3'd0, 3'd7, 1'b1, 1'b0);
    chk("b2b mask_rdy", 32'(mask_rdy), 32'd1);
    @(posedge clk);
    #1;
    mask_vld = 1'b0;
    mask     = 8'h00;
    chk_beat("b2b 0F", 3'd0, 3'd3, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk_idle("b2b done");

    // All-zero mask
    send_mask(8'h00);
`ifdef MASK_RUN_DECODE_ZERO_BEAT_EN
    chk_beat("zero beat", 3'd0, 3'd0, 1'b1, 1'b1);
    chk("zero mask_rdy", 32'(mask_rdy), 32'd1);
    @(posedge clk);
    #1;
    chk_idle("zero done");
`else
    for (int c = 0; c < 3; c++) begin
      chk_idle($sformatf("zero drop%0d", c));
      @(posedge clk);
      #1;
    end
`endif

    // Reset mid-scan of 0xAA, then 0x01 gives a single beat
    send_mask(8'hAA);
    chk_beat("rst b0", 3'd1, 3'd1, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk_beat("rst b1", 3'd3, 3'd3, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk_idle("rst async");
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk_idle($sformatf("rst flushed%0d", c));
    end
    send_mask(8'h01);
    chk_beat("rst 01", 3'd0, 3'd0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk_idle("rst 01 done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mask_run_decode.md
MASK_RUN_DECODE -- requirements
Module: mask_run_decode

Interface
REQ-001 SHALL have parameter MW, default 8, meaning byte-mask width in bits (power of two, 2..64).
REQ-002 SHALL have parameter BW, default 3, meaning byte-index width, equal to log2(MW).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port mask, input, MW bits: byte-enable mask; bit i set means byte i is enabled.
REQ-006 SHALL have port mask_vld, input, 1 bit: mask is valid.
REQ-007 SHALL have port mask_rdy, output, 1 bit: block accepts mask this cycle.
REQ-008 SHALL have port strtbyte, output, BW bits: first byte index of the current run.
REQ-009 SHALL have port endbyte, output, BW bits: last byte index of the current run, inclusive.
REQ-010 SHALL have port run_last, output, 1 bit: current run is the final run of its mask.
REQ-011 SHALL have port run_zero, output, 1 bit: current beat describes an all-zero mask.
REQ-012 SHALL have port run_vld, output, 1 bit: run outputs are valid.
REQ-013 SHALL have port run_rdy, input, 1 bit: consumer accepts the run.

Function
REQ-014 SHALL decompose each accepted mask into maximal contiguous runs of set bits and emit them one beat per run, in ascending strtbyte order.
REQ-015 SHALL use an FSM with two states: IDLE (no residual mask) and SCAN (residual mask held, run_vld=1).
REQ-016 SHALL accept a mask on mask_vld && mask_rdy, load it into the residual register, and go to SCAN; the first run_vld SHALL occur the next cycle, a latency of 1.
REQ-017 SHALL drive mask_rdy = (state==IDLE) || (run_vld && run_rdy && run_last), so a new mask can be accepted back-to-back with no bubble.
REQ-018 SHALL compute, in SCAN, strtbyte as the lowest set residual bit and endbyte as (lowest clear bit above strtbyte) minus 1, or MW-1 if no clear bit exists.
REQ-019 SHALL assert run_last when the residual, with bits strtbyte..endbyte cleared, is zero.
REQ-020 SHALL, on run_vld && run_rdy, clear bits strtbyte..endbyte from the residual, and go to IDLE if run_last is set and no new mask is accepted.
REQ-021 SHALL hold strtbyte, endbyte, run_last, run_zero and run_vld stable while run_vld && !run_rdy.
REQ-022 SHALL ignore mask and mask_vld while mask_rdy=0.
REQ-023 SHALL drive strtbyte, endbyte, run_last and run_zero to 0 whenever run_vld=0.
REQ-024 SHALL emit a single beat with strtbyte=0, endbyte=MW-1, run_last=1 for an all-ones mask.

Reset
REQ-025 SHALL, on reset assertion, immediately force state=IDLE, residual=0, run_vld=0, strtbyte=0, endbyte=0, run_last=0, run_zero=0, and mask_rdy=1 after release.
REQ-026 SHALL discard any partially emitted mask when reset is asserted mid-SCAN, with no remaining runs emitted after reset release.

Configuration
REQ-027 SHALL, with macro MASK_RUN_DECODE_ZERO_BEAT_EN defined, emit one beat for an all-zero mask with run_zero=1, run_last=1, strtbyte=0 and endbyte=0, under the same handshake.
REQ-028 SHALL, without MASK_RUN_DECODE_ZERO_BEAT_EN, accept an all-zero mask, discard it with no output beat, remain in IDLE, and tie run_zero to 0.

Verification
REQ-029 SHALL cover: mask=8'b0011_1100, run_rdy=1 -> one beat (2,5), run_last=1 at cycle N+1.
REQ-030 SHALL cover: mask=8'b1000_0001 -> beats (0,0,last=0) then (7,7,last=1); mask_rdy=1 during the second beat.
REQ-031 SHALL cover: mask=8'b0101_0101 with run_rdy low for 3 cycles on beat 2 -> four beats (0,0),(2,2),(4,4),(6,6) with outputs stable during the stall.
REQ-032 SHALL cover: masks 8'hFF then 8'h0F back-to-back -> (0,7,last) then (0,3,last) on consecutive cycles, with no bubble.
REQ-033 SHALL cover: mask=8'h00 -> one run_zero beat with the macro defined; no beat and mask_rdy staying 1 without it.
REQ-034 SHALL cover: reset asserted after the first beat of 8'b1010_1010 -> run_vld=0 asynchronously, and the next mask 8'h01 yields only (0,0,last).
